// File: rtl/ssd1306_microcode_sequencer.sv
// Microcode sequencer for SSD1306 bring-up: walks the ROM from address 0, sends CMD/DAT bytes,
// runs DLY waits and halts on END. Define SSD1306_SEQ_JUMP_EN to turn END with arg != 8'hFF into a jump.
module ssd1306_microcode_sequencer #(
  parameter int ROM_SIZE   = 40,
  parameter int DELAY_UNIT = 1000,
  localparam int ADDRESS_BITS = $clog2(ROM_SIZE),
  localparam int CNT_W        = 8 + $clog2(DELAY_UNIT + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDRESS_BITS-1:0] rom_address,
  input  logic [9:0]              rom_data,
  input  logic                    rom_address_overflow,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_dc,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_DELAY = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DU  = CNT_W'(DELAY_UNIT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic                    wrap_q, wrap_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_dc_q, tx_dc_d;
  logic                    tx_valid_q, tx_valid_d;

  logic [1:0]              op;
  logic [7:0]              arg;
  logic [ADDRESS_BITS:0]   addr_inc;
  logic [CNT_W-1:0]        dly_load;

  assign op       = rom_data[9:8];
  assign arg      = rom_data[7:0];
  // The extra top bit is the carry-out that marks a wrap past the last address.
  assign addr_inc = {1'b0, addr_q} + {{ADDRESS_BITS{1'b0}}, 1'b1};
  assign dly_load = {{(CNT_W-8){1'b0}}, arg} * DU - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wrap_q     <= 1'b0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_dc_q    <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wrap_q     <= wrap_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_dc_q    <= tx_dc_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Transmit handshake: a byte moves on every rising edge where tx_valid & tx_ready; while tx_valid
  // is high, tx_data and tx_dc do not change, and tx_ready with tx_valid low has no effect.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wrap_d     = wrap_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_dc_d    = tx_dc_q;
    tx_valid_d = tx_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          wrap_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rom_address_overflow || wrap_q) begin
          state_d = S_DONE;
        end else begin
          unique case (op)
            2'b00, 2'b01: begin
              tx_data_d  = arg;
              tx_dc_d    = op[0];
              tx_valid_d = 1'b1;
              state_d    = S_SEND;
            end
            2'b10: begin
              if (arg == 8'd0) begin
                addr_d = addr_inc[ADDRESS_BITS-1:0];
                wrap_d = addr_inc[ADDRESS_BITS];
              end else begin
                cnt_d   = dly_load;
                state_d = S_DELAY;
              end
            end
            default: begin
`ifdef SSD1306_SEQ_JUMP_EN
              if (arg != 8'hFF) begin
                addr_d = arg[ADDRESS_BITS-1:0];
              end else begin
                state_d = S_DONE;
              end
`else
              state_d = S_DONE;
`endif
            end
          endcase
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          addr_d     = addr_inc[ADDRESS_BITS-1:0];
          wrap_d     = addr_inc[ADDRESS_BITS];
          state_d    = S_FETCH;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          addr_d  = addr_inc[ADDRESS_BITS-1:0];
          wrap_d  = addr_inc[ADDRESS_BITS];
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_FETCH) || (state_q == S_SEND) || (state_q == S_DELAY);
  assign done        = (state_q == S_DONE);
  assign rom_address = addr_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_dc       = tx_dc_q;
  assign state_dbg   = state_q;

endmodule
